// File: rtl/dwt_line_pairer.sv
// Raster-to-line-pair adapter for a vertical 9/7 DWT: buffers each even line as
// fixed-point coefficients and emits {odd, even} coefficient pairs on the odd line.
module dwt_line_pairer #(
  parameter int unsigned PixelWidth   = 8,
  parameter int unsigned DataWidth    = 24,
  parameter int unsigned Point        = 16,
  parameter int unsigned MaxLineWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     s_sof_i,
  input  logic                     s_eol_i,
  input  logic [PixelWidth-1:0]    s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_sof_o,
  output logic                     m_eol_o,
  output logic [2*DataWidth-1:0]   m_data_o,
  output logic                     err_o
);

  localparam int unsigned ColWidth   = (MaxLineWidth > 1) ? $clog2(MaxLineWidth) : 1;
  localparam int unsigned WidthWidth = $clog2(MaxLineWidth + 1);
  localparam int unsigned Shift      = Point - PixelWidth;
  localparam logic [ColWidth-1:0] LastCol = ColWidth'(MaxLineWidth - 1);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ColWidth-1:0]     col_q, col_d;
  logic [WidthWidth-1:0]   width_q, width_d;
  logic                    pend_sof_q, pend_sof_d;
  logic                    err_q, err_d;
  logic                    run_q;
  logic                    m_valid_q, m_valid_d;
  logic                    m_sof_q, m_sof_d;
  logic                    m_eol_q, m_eol_d;
  logic [2*DataWidth-1:0]  m_data_q, m_data_d;

  logic [DataWidth-1:0]    line_buf [MaxLineWidth];
  logic                    buf_we;
  logic [ColWidth-1:0]     buf_idx;
  logic [ColWidth-1:0]     wr_idx;
  logic                    at_end;
  logic                    accept;

  // Level shift: flipping the MSB of an unsigned pixel yields pixel - 2^(PixelWidth-1).
  logic signed [PixelWidth-1:0] centred;
  logic signed [DataWidth-1:0]  coeff;

  assign centred = {~s_data_i[PixelWidth-1], s_data_i[PixelWidth-2:0]};
  assign coeff   = DataWidth'(centred) <<< Shift;

  // run_q keeps the input closed while in reset and for the first cycle after it.
  assign s_ready_o = run_q & ((state_q == EVEN) | ~m_valid_q | m_ready_i);
  assign accept    = s_valid_i & s_ready_o;

  // Next-state and output-register logic
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    width_d    = width_q;
    pend_sof_d = pend_sof_q;
    err_d      = err_q;
    m_valid_d  = m_valid_q;
    m_sof_d    = m_sof_q;
    m_eol_d    = m_eol_q;
    m_data_d   = m_data_q;
    buf_we     = 1'b0;
    buf_idx    = col_q;
    wr_idx     = col_q;
    at_end     = 1'b0;

    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      EVEN: begin
        if (accept) begin
          // A mid-line start of frame restarts the line at column 0.
          wr_idx  = (s_sof_i && (col_q != '0)) ? '0 : col_q;
          buf_we  = 1'b1;
          buf_idx = wr_idx;
          if (s_sof_i) begin
            pend_sof_d = 1'b1;
            if (col_q != '0) begin
              err_d = 1'b1;
            end
          end
          if (s_eol_i || (wr_idx == LastCol)) begin
            width_d = WidthWidth'(wr_idx) + WidthWidth'(1);
            col_d   = '0;
            state_d = ODD;
            if (!s_eol_i) begin
              err_d = 1'b1;
            end
          end else begin
            col_d = wr_idx + ColWidth'(1);
          end
        end
      end

      ODD: begin
        if (accept) begin
          if (s_sof_i) begin
            // Unexpected frame start: abandon the pair, beat opens a new even line.
            err_d      = 1'b1;
            buf_we     = 1'b1;
            buf_idx    = '0;
            pend_sof_d = 1'b1;
            if (s_eol_i) begin
              width_d = WidthWidth'(1);
              col_d   = '0;
              state_d = ODD;
            end else begin
              col_d   = ColWidth'(1);
              state_d = EVEN;
            end
          end else begin
            at_end     = (WidthWidth'(col_q) + WidthWidth'(1)) == width_q;
            m_valid_d  = 1'b1;
            m_data_d   = {coeff, line_buf[col_q]};
            m_sof_d    = pend_sof_q;
            pend_sof_d = 1'b0;
            m_eol_d    = s_eol_i | at_end;
            if (s_eol_i != at_end) begin
              err_d = 1'b1;
            end
            if (s_eol_i || at_end) begin
              col_d   = '0;
              state_d = EVEN;
            end else begin
              col_d = col_q + ColWidth'(1);
            end
          end
        end
      end

      default: state_d = EVEN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EVEN;
      col_q      <= '0;
      width_q    <= '0;
      pend_sof_q <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eol_q    <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      width_q    <= width_d;
      pend_sof_q <= pend_sof_d;
      err_q      <= err_d;
      run_q      <= 1'b1;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eol_q    <= m_eol_d;
      m_data_q   <= m_data_d;
    end
  end

  // Even-line storage; only read at columns written by the current even line.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      line_buf[buf_idx] <= coeff;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dwt_line_pairer.sv
// Self-checking bench for dwt_line_pairer: random frames and stalls against a
// frame-level pairing model, plus directed framing-error and reset scenarios.
module tb_dwt_line_pairer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        s_valid_i, s_ready_o, s_sof_i, s_eol_i;
  logic [7:0]  s_data_i;
  logic        m_valid_o, m_ready_i, m_sof_o, m_eol_o;
  logic [47:0] m_data_o;
  logic        err_o;

  dwt_line_pairer dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_sof_i   (s_sof_i),
    .s_eol_i   (s_eol_i),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_sof_o   (m_sof_o),
    .m_eol_o   (m_eol_o),
    .m_data_o  (m_data_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eol;
    bit         odd;
  } in_beat_t;

  typedef struct {
    logic [47:0] data;
    bit          sof;
    bit          eol;
  } out_beat_t;

  in_beat_t    in_q[$];
  out_beat_t   exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out;
  logic [47:0] first_data;
  logic        first_sof;

  // (pixel - 128) * 256 as a 24-bit two's-complement coefficient
  function automatic logic [23:0] coeff(input int p);
    return 24'((p - 128) * 256);
  endfunction

  function automatic int rnd_pix();
    return int'($urandom_range(0, 255));
  endfunction

  // Frame model: even rows are stored, each odd row pairs column-wise with the row above.
  task automatic add_frame(input int w, input int h, input bit pattern,
                           input bit drop_even_eol, input bit drop_odd_eol);
    int pix [0:7][0:31];
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix[r][c] = pattern ? (16 * r + c) : rnd_pix();
        in_q.push_back('{data: 8'(pix[r][c]), sof: (r == 0 && c == 0),
                         eol: (c == w - 1) && !((r % 2 == 0) ? drop_even_eol : drop_odd_eol),
                         odd: (r % 2 == 1)});
      end
      if (r % 2 == 1) begin
        for (int c = 0; c < w; c++) begin
          exp_q.push_back('{data: {coeff(pix[r][c]), coeff(pix[r-1][c])},
                            sof: (r == 1 && c == 0), eol: (c == w - 1)});
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    in_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Drives in_q and checks every output handshake against exp_q.
  // mode: 0 ready high, 1 ready toggling, 2 random ready.
  task automatic run_stream(input int mode, input bit clean, input bit gaps);
    int          idx = 0;
    int          cyc = 0;
    bit          presenting = 0;
    bit          prev_stall = 0;
    logic [49:0] held = '0;
    out_beat_t   e;
    bit          exp_rdy;
    n_out = 0;
    while ((idx < in_q.size() || exp_q.size() != 0) && cyc < 4000) begin
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = (cyc % 2 == 0);
        default: m_ready_i = ($urandom_range(0, 2) != 0);
      endcase
      if (idx < in_q.size()) begin
        if (!presenting) presenting = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_valid_i = presenting;
        s_data_i  = in_q[idx].data;
        s_sof_i   = in_q[idx].sof;
        s_eol_i   = in_q[idx].eol;
      end else begin
        s_valid_i = 1'b0;
      end
      #1;
      if (prev_stall) begin
        n_checks++;
        if (m_valid_o !== 1'b1 || {m_data_o, m_sof_o, m_eol_o} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h", m_valid_o,
                   {m_data_o, m_sof_o, m_eol_o}, held);
        end
      end
      if (clean && s_valid_i) begin
        exp_rdy = !(in_q[idx].odd && m_valid_o && !m_ready_i);
        n_checks++;
        if (s_ready_o !== exp_rdy) begin
          n_fail++;
          $display("FAIL s_ready beat %0d: got %b, required %b", idx, s_ready_o, exp_rdy);
        end
      end
      if (m_valid_o && m_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got data=%h, required no beat", m_data_o);
        end else begin
          e = exp_q.pop_front();
          if (m_data_o !== e.data || m_sof_o !== e.sof || m_eol_o !== e.eol) begin
            n_fail++;
            $display("FAIL out_beat %0d: got %h sof=%b eol=%b, required %h sof=%b eol=%b",
                     n_out, m_data_o, m_sof_o, m_eol_o, e.data, e.sof, e.eol);
          end
        end
        if (n_out == 0) begin
          first_data = m_data_o;
          first_sof  = m_sof_o;
        end
        n_out++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      held       = {m_data_o, m_sof_o, m_eol_o};
      if (s_valid_i && s_ready_o) begin
        idx++;
        presenting = 1'b0;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    n_checks++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL stream_timeout: consumed %0d of %0d, %0d beats outstanding",
               idx, in_q.size(), exp_q.size());
    end else if (m_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_stream: got m_valid=%b, required 0", m_valid_o);
    end
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    s_valid_i = 1'b1;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = 8'd77;
    m_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", s_ready_o); end
    n_checks++;
    if ({m_valid_o, m_sof_o, m_eol_o, err_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000", {m_valid_o, m_sof_o, m_eol_o, err_o});
    end
    n_checks++;
    if (m_data_o !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", m_data_o); end
    s_valid_i = 1'b0;
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n_checks++;
    if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, required 1", s_ready_o); end
  endtask

  task automatic test_frame_4x4(input int mode);
    apply_reset();
    add_frame(4, 4, 1'b1, 1'b0, 1'b0);
    run_stream(mode, 1'b1, 1'b0);
    n_checks++;
    if (n_out != 8) begin n_fail++; $display("FAIL frame4x4_count: got %0d, required 8", n_out); end
    n_checks++;
    if (first_data !== 48'hFF9000_FF8000 || first_sof !== 1'b1) begin
      n_fail++; $display("FAIL frame4x4_first: got %h sof=%b, required ff9000ff8000 sof=1", first_data, first_sof);
    end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL frame4x4_err: got %b, required 0", err_o); end
  endtask

  task automatic test_back_to_back();
    int total = 0;
    int w, h;
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      w = int'($urandom_range(1, 8));
      h = 2 * int'($urandom_range(1, 3));
      total += w * h / 2;
      add_frame(w, h, 1'b0, 1'b0, 1'b0);
    end
    run_stream(2, 1'b1, 1'b1);
    n_checks++;
    if (n_out != total) begin n_fail++; $display("FAIL b2b_count: got %0d, required %0d", n_out, total); end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b, required 0", err_o); end
  endtask

  task automatic test_extremes();
    apply_reset();
    in_q.push_back('{data: 8'd0, sof: 1'b1, eol: 1'b1, odd: 1'b0});
    in_q.push_back('{data: 8'd255, sof: 1'b0, eol: 1'b1, odd: 1'b1});
    exp_q.push_back('{data: {coeff(255), coeff(0)}, sof: 1'b1, eol: 1'b1});
    run_stream(0, 1'b1, 1'b0);
    n_checks++;
    if (first_data !== 48'h007F00_FF8000) begin
      n_fail++; $display("FAIL extremes: got %h, required 007f00ff8000", first_data);
    end
  endtask

  task automatic test_short_odd();
    int e [4];
    int o [3];
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      e[c] = rnd_pix();
      in_q.push_back('{data: 8'(e[c]), sof: (c == 0), eol: (c == 3), odd: 1'b0});
    end
    for (int c = 0; c < 3; c++) begin
      o[c] = rnd_pix();
      in_q.push_back('{data: 8'(o[c]), sof: 1'b0, eol: (c == 2), odd: 1'b1});
      exp_q.push_back('{data: {coeff(o[c]), coeff(e[c])}, sof: (c == 0), eol: (c == 2)});
    end
    run_stream(2, 1'b0, 1'b1);
    n_checks++;
    if (n_out != 3 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL short_odd: got beats=%0d err=%b, required beats=3 err=1", n_out, err_o);
    end
  endtask

  task automatic test_odd_sof();
    int e [4];
    int n [4];
    int o [4];
    int o0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      e[c] = rnd_pix();
      n[c] = rnd_pix();
      o[c] = rnd_pix();
      in_q.push_back('{data: 8'(e[c]), sof: (c == 0), eol: (c == 3), odd: 1'b0});
    end
    o0 = rnd_pix();
    in_q.push_back('{data: 8'(o0), sof: 1'b0, eol: 1'b0, odd: 1'b1});
    exp_q.push_back('{data: {coeff(o0), coeff(e[0])}, sof: 1'b1, eol: 1'b0});
    for (int c = 0; c < 4; c++) begin
      in_q.push_back('{data: 8'(n[c]), sof: (c == 0), eol: (c == 3), odd: 1'b0});
    end
    for (int c = 0; c < 4; c++) begin
      in_q.push_back('{data: 8'(o[c]), sof: 1'b0, eol: (c == 3), odd: 1'b1});
      exp_q.push_back('{data: {coeff(o[c]), coeff(n[c])}, sof: (c == 0), eol: (c == 3)});
    end
    run_stream(1, 1'b0, 1'b0);
    n_checks++;
    if (n_out != 5 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL odd_sof: got beats=%0d err=%b, required beats=5 err=1", n_out, err_o);
    end
  endtask

  task automatic test_missing_eol();
    apply_reset();
    add_frame(3, 2, 1'b0, 1'b0, 1'b1);
    run_stream(2, 1'b0, 1'b1);
    n_checks++;
    if (n_out != 3 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL odd_no_eol: got beats=%0d err=%b, required beats=3 err=1", n_out, err_o);
    end
    apply_reset();
    add_frame(32, 2, 1'b0, 1'b1, 1'b0);
    run_stream(0, 1'b0, 1'b0);
    n_checks++;
    if (n_out != 32 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL max_width: got beats=%0d err=%b, required beats=32 err=1", n_out, err_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] px [3];
    int wait_cnt;
    px[0] = 8'd10; px[1] = 8'd20; px[2] = 8'd30;
    apply_reset();
    m_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_valid_i = 1'b1;
      s_data_i  = px[b];
      s_sof_i   = (b == 0);
      s_eol_i   = (b == 1);
      wait_cnt  = 0;
      #1;
      while (!s_ready_o && wait_cnt < 20) begin
        @(posedge clk_i);
        #1;
        wait_cnt++;
      end
      n_checks++;
      if (wait_cnt >= 20) begin n_fail++; $display("FAIL mid_reset_drive: beat %0d never accepted", b); end
      @(posedge clk_i);
      #1;
    end
    s_valid_i = 1'b0;
    n_checks++;
    if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pending: got %b, required 1", m_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({m_valid_o, m_sof_o, m_eol_o, err_o, s_ready_o} !== 5'b0 || m_data_o !== 48'h0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b data=%h, required 0", {m_valid_o, m_sof_o, m_eol_o, err_o, s_ready_o}, m_data_o);
    end
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    add_frame(2, 2, 1'b0, 1'b0, 1'b0);
    run_stream(2, 1'b1, 1'b1);
    n_checks++;
    if (n_out != 2 || first_sof !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_frame: got beats=%0d sof=%b err=%b, required beats=2 sof=1 err=0", n_out, first_sof, err_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    test_reset();
    test_frame_4x4(0);
    test_frame_4x4(1);
    test_extremes();
    test_back_to_back();
    test_short_odd();
    test_odd_sof();
    test_missing_eol();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
